// File: rtl/utils_top.sv
// Shared opcode/funct3 constants and state type for the execute resolve stage.
// Imported by execute_resolve and execute_branch_cmp.
package utils_top;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    typedef enum logic {
        RUN  = 1'b0,
        KILL = 1'b1
    } resolve_state_t;

endpackage

// File: rtl/execute_branch_cmp.sv
// Branch taken decision from funct3 and the ALU compare result.
// BLT/BLTU/BGE/BGEU rely on the ALU producing the compare flag in bit 0.
module execute_branch_cmp
    import utils_top::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] alu_y,
    output logic            taken
);

    // Decode funct3 into the taken flag; reserved encodings never branch.
    always_comb begin
        taken = 1'b0;
        unique case (funct3)
            BEQ:         taken = (alu_y == '0);
            BNE:         taken = (alu_y != '0);
            BLT, BLTU:   taken = alu_y[0];
            BGE, BGEU:   taken = ~alu_y[0];
            default:     taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/execute_resolve.sv
// EX resolve stage: branch/jump resolution, redirect + flush, EX/MEM register.
// Optional macro EXECUTE_RESOLVE_MISALIGN_EN turns misaligned targets into misalign_exc.
module execute_resolve
    import utils_top::*;
#(
    parameter int XLEN        = 32,
    parameter int KILL_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [6:0]      in_opcode,
    input  logic [2:0]      in_funct3,
    input  logic [4:0]      in_rd,
    input  logic [XLEN-1:0] in_imm,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [XLEN-1:0] alu_y,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [XLEN-1:0] out_rs2_data,
    output logic [4:0]      out_rd,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_funct3,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            misalign_exc
);

    resolve_state_t  state, state_nx;
    logic [2:0]      cnt, cnt_nx;
    logic            accept;
    logic            is_jal, is_jalr, is_br, jump;
    logic            br_taken, redir, mis, fire;
    logic [XLEN-1:0] pc_plus4, br_target, target, result_nx;

    execute_branch_cmp #(.XLEN(XLEN)) u_cmp (
        .funct3 (in_funct3),
        .alu_y  (alu_y),
        .taken  (br_taken)
    );

    assign is_jal    = (in_opcode == OP_JAL);
    assign is_jalr   = (in_opcode == OP_JALR);
    assign is_br     = (in_opcode == OP_BRANCH);
    assign jump      = is_jal | is_jalr;
    assign pc_plus4  = in_pc + XLEN'(4);
    assign br_target = in_pc + in_imm;
    assign redir     = jump | (is_br & br_taken);

    // Pick the redirect target; JALR clears bit 0 of the ALU sum.
    always_comb begin
        target = br_target;
        unique case (1'b1)
            is_jal:  target = alu_y;
            is_jalr: target = alu_y & ~XLEN'(1);
            default: target = br_target;
        endcase
    end

`ifdef EXECUTE_RESOLVE_MISALIGN_EN
    assign mis = redir & (target[1:0] != 2'b00);
`else
    assign mis = 1'b0;
`endif

    assign fire     = redir & ~mis;
    assign in_ready = (state == RUN) & (~out_valid | out_ready);
    assign accept   = in_valid & in_ready;

    // Misaligned redirects carry the faulting target down to MEM instead.
    always_comb begin
        result_nx = alu_y;
        if (mis)       result_nx = target;
        else if (jump) result_nx = pc_plus4;
    end

    // Kill-window next state: a redirect blocks the next KILL_CYCLES inputs.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            RUN: begin
                if (accept & fire) begin
                    state_nx = KILL;
                    cnt_nx   = 3'(KILL_CYCLES);
                end
            end
            KILL: begin
                cnt_nx = cnt - 3'd1;
                if (cnt == 3'd1) begin
                    state_nx = RUN;
                    cnt_nx   = 3'd0;
                end
            end
            default: begin
                state_nx = RUN;
                cnt_nx   = 3'd0;
            end
        endcase
    end

    // Kill-window state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            cnt   <= 3'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // EX/MEM payload register plus the single-cycle redirect pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid      <= 1'b0;
            out_result     <= '0;
            out_rs2_data   <= '0;
            out_rd         <= '0;
            out_opcode     <= '0;
            out_funct3     <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            redirect_valid <= accept & fire;
            if (accept & fire) redirect_pc <= target;
            if (accept) begin
                out_valid    <= 1'b1;
                out_result   <= result_nx;
                out_rs2_data <= in_rs2_data;
                out_rd       <= is_br ? 5'd0 : in_rd;
                out_opcode   <= in_opcode;
                out_funct3   <= in_funct3;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef EXECUTE_RESOLVE_MISALIGN_EN
    // Exception pulse lines up with where the suppressed redirect would be.
    always_ff @(posedge clk) begin
        if (rst) misalign_exc <= 1'b0;
        else     misalign_exc <= accept & mis;
    end
`else
    assign misalign_exc = 1'b0;
`endif

endmodule

// File: doc/execute_resolve.md
Name: execute_resolve

Overview:
- Stage directly downstream of the execute ALU.
- Consumes the ALU output y together with the ID/EX payload (pc, opcode, funct3, rd, imm, rs2 data).
- Resolves branches and jumps, and generates the pc redirect and upstream flush.
- Registers the EX/MEM payload behind a valid/ready handshake.
- Includes a small kill-window state machine that drops wrong-path instructions after a redirect.

Parameters:
- XLEN, 32: datapath width.
- KILL_CYCLES, 2: cycles after a redirect during which in_valid is ignored (1..7).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  ID/EX entry valid.
- in_ready  output  1  stage can accept this cycle.
- in_pc  input  XLEN  instruction pc.
- in_opcode  input  7  opcode, same value driven to the ALU.
- in_funct3  input  3  funct3.
- in_rd  input  5  destination register.
- in_imm  input  XLEN  sign-extended immediate.
- in_rs2_data  input  XLEN  store data.
- alu_y  input  XLEN  ALU result for this instruction.
- out_valid  output  1  EX/MEM entry valid.
- out_ready  input  1  MEM accepts.
- out_result  output  XLEN  writeback/address value.
- out_rs2_data  output  XLEN  store data.
- out_rd  output  5  destination register.
- out_opcode  output  7  opcode.
- out_funct3  output  3  funct3.
- redirect_valid  output  1  one-cycle redirect pulse, also the upstream flush.
- redirect_pc  output  XLEN  new fetch pc.
- misalign_exc  output  1  target misaligned (optional feature only).

Behaviour:
- Reset: every output register is 0 (out_valid, out_*, redirect_valid, redirect_pc, misalign_exc); FSM enters RUN; kill counter is 0.
- Handshake:
  - in_ready = (state==RUN) & (!out_valid | out_ready).
  - Accept = in_valid & in_ready.
  - On accept, the payload is registered and out_valid=1 on the next cycle (latency 1).
  - If out_valid & out_ready & !accept, out_valid clears.
  - Payload is held stable while out_valid & !out_ready.
- Result selection:
  - JAL/JALR (7'b1101111 / 7'b1100111): out_result = in_pc+4.
  - All other opcodes: out_result = alu_y.
  - All adds are modulo 2^XLEN.
- Branch decision (opcode 7'b1100011), using alu_y:
  - BEQ(000): taken = (alu_y==0).
  - BNE(001): taken = (alu_y!=0).
  - BLT(100)/BLTU(110): taken = alu_y[0].
  - BGE(101)/BGEU(111): taken = !alu_y[0].
  - funct3 010/011: never taken.
  - Branches write out_rd=0.
- Targets:
  - Branch target = in_pc+in_imm.
  - JAL target = alu_y.
  - JALR target = alu_y & ~1.
- Redirect timing:
  - On the accept of a taken branch or any jump, redirect_valid=1 and redirect_pc=target on the next cycle.
  - redirect_valid lasts exactly one cycle.
- FSM:
  - RUN: accepting. On a redirect-producing accept → KILL, counter=KILL_CYCLES.
  - KILL: in_ready=0; in_valid is ignored and dropped (upstream is flushed by redirect_valid); counter decrements each cycle; at counter==1 → RUN.
  - Back-to-back redirects are impossible, because KILL blocks acceptance.
- Boundaries:
  - An out_ready stall does not delay the redirect pulse; the redirect is issued at accept, not at drain.
  - Reset mid-KILL returns the FSM to RUN with out_valid=0 and no redirect.
  - A not-taken branch passes through with no redirect and stays in RUN.
  - A pc near 2^XLEN wraps on +4 and +imm.

Optional Feature:
- Macro: EXECUTE_RESOLVE_MISALIGN_EN.
- Defined:
  - If a redirect target has target[1:0]!=0, redirect is suppressed.
  - misalign_exc=1 for one cycle, aligned with the cycle redirect_valid would have fired.
  - The instruction still goes to MEM with out_result=target.
  - The FSM stays in RUN.
- Undefined: misalign_exc is tied to 0 and targets are used unchecked.

Decomposition:
- The shared package (utils_top) holds:
  - Opcode constants OP_JAL, OP_JALR, OP_BRANCH.
  - Branch funct3 constants BEQ/BNE/BLT/BGE/BLTU/BGEU.
  - A resolve_state_t enum {RUN, KILL}.
- One sub-module, execute_branch_cmp: combinational taken decision from funct3 and alu_y.

Test Plan:
- BEQ pc=0x100, imm=0x20, alu_y=0, accept at t → redirect_valid=1 at t+1 with redirect_pc=0x120; in_ready=0 for 2 cycles; out_rd=0.
- BNE alu_y=0 → no redirect; out_valid=1 at t+1; in_ready stays 1.
- JALR pc=0x200, rd=1, alu_y=0x305 → redirect_pc=0x304, out_result=0x204, out_rd=1.
- ADD alu_y=0xDEADBEEF with out_ready=0 for 3 cycles → out_result held; in_ready=0; the next instruction is accepted in the cycle out_ready=1.
- Taken BLT (alu_y=1), then in_valid=1 every cycle → the two following instructions are dropped; the third is accepted; rst asserted during KILL → all outputs 0, in_ready=1 next cycle.
- With EXECUTE_RESOLVE_MISALIGN_EN defined: JAL alu_y=0x102 → misalign_exc=1 and redirect_valid=0 at t+1, out_valid=1.
